// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch requests, reads the word store through a fixed
// LATENCY-stage pipeline and returns instr/pc/err in order through a credit-protected queue.
module imem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_pc,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_instr,
    output logic [31:0]       resp_pc,
    output logic              resp_err,
    input  logic              resp_ready,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [15:0]       resp_count
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned OCC_W = $clog2(QDEPTH + LATENCY + 1);

    logic [31:0] mem [2**ADDR_W];

    logic              pipe_valid [LATENCY];
    logic [31:0]       pipe_pc    [LATENCY];
    logic [31:0]       pipe_data  [LATENCY];
    logic              pipe_err   [LATENCY];

    logic [31:0]       q_instr [QDEPTH];
    logic [31:0]       q_pc    [QDEPTH];
    logic              q_err   [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              req_err;
    logic [ADDR_W-1:0] req_idx;
    logic              accept;
    logic              push;
    logic              pop;
    logic              q_full;
    logic [OCC_W-1:0]  occ;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_err = (req_pc[1:0] != 2'b00) || (req_pc[31:ADDR_W+2] != '0);
    assign req_idx = req_pc[ADDR_W+1:2];

    // Credits cover both the pipeline and the queue, so the pipeline never has to stall.
    always_comb begin
        occ = OCC_W'(count);
        for (int i = 0; i < LATENCY; i++) begin
            occ = occ + OCC_W'(pipe_valid[i]);
        end
    end

    assign pop       = resp_valid && resp_ready;
    assign req_ready = !reset && !flush && ((occ - OCC_W'(pop)) < OCC_W'(QDEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = pipe_valid[LATENCY-1] && !flush && !reset;
    assign q_full    = (count == CNT_W'(QDEPTH));

    // Store is never cleared; reads below see the pre-write word on a same-cycle load.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
        pipe_pc[0]   <= req_pc;
        pipe_err[0]  <= req_err;
        pipe_data[0] <= req_err ? 32'h0 : mem[req_idx];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_pc[i]   <= pipe_pc[i-1];
            pipe_err[i]  <= pipe_err[i-1];
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= pipe_data[LATENCY-1];
                q_pc[wr_ptr]    <= pipe_pc[LATENCY-1];
                q_err[wr_ptr]   <= pipe_err[LATENCY-1];
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A handshake in the flush cycle still counts as consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_count <= 16'h0;
        end else if (pop) begin
            resp_count <= resp_count + 16'h1;
        end
    end

    assign resp_valid = (count != '0);
    assign resp_instr = resp_valid ? q_instr[rd_ptr] : 32'h0;
    assign resp_pc    = resp_valid ? q_pc[rd_ptr]    : 32'h0;
    assign resp_err   = resp_valid ? q_err[rd_ptr]   : 1'b0;

    queue_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && q_full && !pop));

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: program load, ordering, errors, backpressure,
// flush, read-before-write and mid-stream reset.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic [31:0] resp_pc;
    logic        resp_err;
    logic        resp_ready;
    logic        flush;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic [15:0] resp_count;

    int checks_total  = 0;
    int checks_passed = 0;

    localparam logic [31:0] W0 = 32'h0000_0013;
    localparam logic [31:0] W1 = 32'h0010_0093;
    localparam logic [31:0] W2 = 32'h0020_0113;
    localparam logic [31:0] W3 = 32'h0030_0193;

    imem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .resp_pc    (resp_pc),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .flush      (flush),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .resp_count (resp_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_resp(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic err);
        check1({tag, "_valid"}, resp_valid, 1'b1);
        check32({tag, "_pc"}, resp_pc, pc);
        check32({tag, "_instr"}, resp_instr, instr);
        check1({tag, "_err"}, resp_err, err);
    endtask

    initial begin
        logic [31:0] words [4];
        logic [31:0] bp_pcs [6];
        int idx;
        int accepted;
        words  = '{W0, W1, W2, W3};
        bp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4};

        reset = 1'b1; req_valid = 1'b1; req_pc = 32'h0; resp_ready = 1'b0; flush = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #1;
        check1("reset_req_ready", req_ready, 1'b0);
        tick(); tick();
        req_valid = 1'b0;
        check1("reset_resp_valid", resp_valid, 1'b0);
        check32("reset_resp_instr", resp_instr, 32'h0);
        check32("reset_resp_pc", resp_pc, 32'h0);
        check1("reset_resp_err", resp_err, 1'b0);
        check32("reset_resp_count", 32'(resp_count), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_addr = 10'(i); load_data = words[i];
            tick();
        end
        load_en = 1'b0;

        // Back-to-back fetch, first response two edges after acceptance.
        resp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 32'h0;
        #1 check1("b2b_ready", req_ready, 1'b1);
        tick();
        req_pc = 32'h4;
        tick();
        req_pc = 32'h8;
        check1("b2b_not_early", resp_valid, 1'b0);
        tick();
        check_resp("b2b_r0", 32'h0, W0, 1'b0);
        req_pc = 32'hC;
        tick();
        check_resp("b2b_r1", 32'h4, W1, 1'b0);
        req_valid = 1'b0;
        tick();
        check_resp("b2b_r2", 32'h8, W2, 1'b0);
        tick();
        check_resp("b2b_r3", 32'hC, W3, 1'b0);
        tick();
        check1("b2b_drained", resp_valid, 1'b0);
        check32("b2b_count", 32'(resp_count), 32'd4);

        // Misaligned and out-of-range requests.
        req_valid = 1'b1; req_pc = 32'h6;
        tick();
        req_pc = 32'h1000;
        tick();
        req_valid = 1'b0;
        tick();
        check_resp("err_misalign", 32'h6, 32'h0, 1'b1);
        tick();
        check_resp("err_range", 32'h1000, 32'h0, 1'b1);
        tick();
        check1("err_drained", resp_valid, 1'b0);
        check32("err_count", 32'(resp_count), 32'd6);

        // Backpressure: only QDEPTH requests get credits.
        resp_ready = 1'b0;
        idx = 0;
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1; req_pc = bp_pcs[idx];
            #1;
            check1("bp_ready", req_ready, (k < 4) ? 1'b1 : 1'b0);
            if (req_ready) begin
                accepted++;
                idx++;
            end
            tick();
        end
        req_valid = 1'b0;
        check32("bp_accepted", 32'(accepted), 32'd4);
        check_resp("bp_hold", 32'h0, W0, 1'b0);
        tick();
        check_resp("bp_stable", 32'h0, W0, 1'b0);
        check1("bp_full_ready", req_ready, 1'b0);
        resp_ready = 1'b1;
        #1 check1("bp_pop_frees_credit", req_ready, 1'b1);
        tick();
        check_resp("bp_r1", 32'h4, W1, 1'b0);
        tick();
        check_resp("bp_r2", 32'h8, W2, 1'b0);
        tick();
        check_resp("bp_r3", 32'hC, W3, 1'b0);
        tick();
        check1("bp_drained", resp_valid, 1'b0);
        check32("bp_count", 32'(resp_count), 32'd10);

        // Flush with three outstanding requests.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_pc = 32'h0;
        tick();
        req_pc = 32'h4;
        tick();
        req_pc = 32'hC;
        tick();
        req_valid = 1'b1; req_pc = 32'h4; flush = 1'b1;
        #1 check1("flush_blocks_req", req_ready, 1'b0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check1("flush_no_resp", resp_valid, 1'b0);
            tick();
        end
        check32("flush_count", 32'(resp_count), 32'd10);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        check1("flush_after_not_early", resp_valid, 1'b0);
        tick();
        check_resp("flush_after", 32'h8, W2, 1'b0);
        tick();
        check1("flush_after_single", resp_valid, 1'b0);
        check32("flush_after_count", 32'(resp_count), 32'd11);

        // Same-cycle load and fetch of word 2 returns the old word.
        load_en = 1'b1; load_addr = 10'd2; load_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_pc = 32'h8;
        tick();
        load_en = 1'b0; req_valid = 1'b0;
        tick();
        tick();
        check_resp("rbw_old", 32'h8, W2, 1'b0);
        req_valid = 1'b1; req_pc = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check_resp("rbw_new", 32'h8, 32'hDEAD_BEEF, 1'b0);
        tick();
        check32("rbw_count", 32'(resp_count), 32'd13);

        // Reset with two responses queued.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_pc = 32'h0;
        tick();
        req_pc = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check_resp("rst_queued", 32'h0, W0, 1'b0);
        reset = 1'b1;
        tick();
        check1("rst_resp_valid", resp_valid, 1'b0);
        check32("rst_resp_count", 32'(resp_count), 32'd0);
        check32("rst_resp_pc", resp_pc, 32'h0);
        check32("rst_resp_instr", resp_instr, 32'h0);
        check1("rst_req_ready", req_ready, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("rst_no_stale", resp_valid, 1'b0);
        end
        resp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 32'hC;
        tick();
        req_pc = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        check_resp("rst_retained_w3", 32'hC, W3, 1'b0);
        tick();
        check_resp("rst_retained_w2", 32'h8, 32'hDEAD_BEEF, 1'b0);
        tick();
        check1("rst_final_drained", resp_valid, 1'b0);
        check32("rst_final_count", 32'(resp_count), 32'd2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
